// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared constants and state type for the sequential divider
package seq_div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/seq_div8by4_if.sv
// rtl/seq_div8by4_if.sv - start/busy/done handshake and operand/result bus of the divider
interface seq_div8by4_if #(
    parameter int DW = 8,
    parameter int VW = 4
);

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic          q_o
);

    logic [VW:0] trial;

    // Shift the next dividend bit into the partial remainder and subtract if it fits.
    // The low VW bits of (trial - divisor) equal the truncated VW-bit difference.
    always_comb begin
        trial = {rem_i, bit_i};
        q_o   = (trial >= {1'b0, divisor_i});
        rem_o = q_o ? (trial[VW-1:0] - divisor_i) : trial[VW-1:0];
    end

endmodule

// File: rtl/seq_div8by4.sv
// rtl/seq_div8by4.sv - multicycle restoring divider, one quotient bit per clock (option: SEQ_DIV_ZERO_CHK_EN)
module seq_div8by4
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    seq_div8by4_if.slave bus
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shf_q, shf_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rmd_q, rmd_d;
    logic          done_q, done_d;
`ifdef SEQ_DIV_ZERO_CHK_EN
    logic          dz_q, dz_d;
`endif

    logic          accept;
    logic          zero_skip;
    logic          finish;
    logic [VW-1:0] step_rem;
    logic          step_q;

    div_step #(.VW(VW)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shf_q[DW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: a start in IDLE launches CALC unless a zero divisor short-circuits it.
    always_comb begin
        accept = (state_q == IDLE) && bus.start;
`ifdef SEQ_DIV_ZERO_CHK_EN
        zero_skip = accept && (bus.divisor == '0);
`else
        zero_skip = 1'b0;
`endif
        finish  = (state_q == CALC) && (cnt_q == LAST);
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !zero_skip) state_d = CALC;
            CALC:    if (cnt_q == LAST)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result outputs; results only change when an operation completes.
    always_comb begin
        cnt_d  = cnt_q;
        shf_d  = shf_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        rmd_d  = rmd_q;
        done_d = finish || zero_skip;
`ifdef SEQ_DIV_ZERO_CHK_EN
        dz_d   = dz_q;
`endif
        if (accept) begin
            shf_d = bus.dividend;
            dvs_d = bus.divisor;
            rem_d = '0;
            cnt_d = '0;
        end
        if (state_q == CALC) begin
            shf_d = {shf_q[DW-2:0], step_q};
            rem_d = step_rem;
            cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
            quo_d = {shf_q[DW-2:0], step_q};
            rmd_d = step_rem;
`ifdef SEQ_DIV_ZERO_CHK_EN
            dz_d  = 1'b0;
`endif
        end
`ifdef SEQ_DIV_ZERO_CHK_EN
        if (zero_skip) begin
            quo_d = '1;
            rmd_d = '0;
            dz_d  = 1'b1;
        end
`endif
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            shf_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            rmd_q  <= '0;
            done_q <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHK_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            shf_q  <= shf_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            rmd_q  <= rmd_d;
            done_q <= done_d;
`ifdef SEQ_DIV_ZERO_CHK_EN
            dz_q   <= dz_d;
`endif
        end
    end

    // Handshake outputs: busy follows CALC, everything else is registered.
    always_comb begin
        bus.busy      = (state_q == CALC);
        bus.done      = done_q;
        bus.quotient  = quo_q;
        bus.remainder = rmd_q;
`ifdef SEQ_DIV_ZERO_CHK_EN
        bus.div_zero  = dz_q;
`else
        bus.div_zero  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_seq_div8by4.sv
// tb/tb_seq_div8by4.sv - scoreboard bench for seq_div8by4 with directed vectors
module tb_seq_div8by4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div8by4_if bus ();

    seq_div8by4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   pass_cnt = 0;
    int   total    = 0;
    int   done_cnt = 0;
    int   cyc      = 0;
    int   d0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: done at cycle %0d with no operation pending", cyc);
            end else begin
                cur = sbq.pop_front();
                chk({cur.name, "_quotient"},  32'(bus.quotient),  32'(cur.q));
                chk({cur.name, "_remainder"}, 32'(bus.remainder), 32'(cur.r));
                chk({cur.name, "_div_zero"},  32'(bus.div_zero),  32'(cur.dz));
                chk({cur.name, "_done_cycle"}, 32'(cyc), 32'(cur.cyc));
                chk({cur.name, "_busy_in_done"}, 32'(bus.busy), 32'd0);
            end
        end
    end

    // Called at posedge+1: drives start for one cycle, optionally registering the expected result.
    task automatic issue(input string name, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic edz,
                         input int lat, input bit push);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sbq.push_back('{eq, er, edz, cyc + lat, name});
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'h5A;
        bus.divisor  = 4'hC;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d results still pending", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",      32'(bus.busy),      32'd0);
        chk("reset_done",      32'(bus.done),      32'd0);
        chk("reset_quotient",  32'(bus.quotient),  32'd0);
        chk("reset_remainder", 32'(bus.remainder), 32'd0);
        chk("reset_div_zero",  32'(bus.div_zero),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 200 / 7 with busy profile over cycles 0..9
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        sbq.push_back('{8'd28, 4'd4, 1'b0, cyc + 9, "d200_7"});
        @(negedge clk);
        chk("busy_cycle0", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("busy_cycle%0d", k), 32'(bus.busy), (k <= 8) ? 32'd1 : 32'd0);
        end
        drain(20);

        issue("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9, 1'b1);
        drain(20);
        issue("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 1'b1);
        drain(20);

        // back-to-back: second start lands in the done cycle of the first
        issue("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 9, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        issue("d100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9, 1'b1);
        drain(25);

`ifdef SEQ_DIV_ZERO_CHK_EN
        issue("dzero", 8'hA6, 4'd0, 8'hFF, 4'd0, 1'b1, 1, 1'b1);
        chk("dzero_busy", 32'(bus.busy), 32'd0);
`else
        issue("dzero", 8'hA6, 4'd0, 8'hFF, 4'h6, 1'b0, 9, 1'b1);
`endif
        drain(20);

        // start while busy is ignored
        d0 = done_cnt;
        issue("ign200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain(20);
        repeat (10) @(posedge clk);
        #1;
        chk("ignore_done_count", 32'(done_cnt - d0), 32'd1);

        // reset mid-operation
        d0 = done_cnt;
        issue("rst200_7", 8'd200, 4'd7, 8'd0, 4'd0, 1'b0, 9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_done",      32'(bus.done),      32'd0);
        chk("midrst_quotient",  32'(bus.quotient),  32'd0);
        chk("midrst_remainder", 32'(bus.remainder), 32'd0);
        chk("midrst_div_zero",  32'(bus.div_zero),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/seq_div8by4.md
Name: seq_div8by4

Overview:
- Sequential restoring divider: unsigned DW-bit dividend ÷ VW-bit divisor → DW-bit quotient, VW-bit remainder.
- Inverse companion to the team's 4-bit array multiplier; multicycle, one quotient bit per clock.
- Used wherever a multiplier product must be scaled back down or range-checked.
- Start/busy/done handshake toward a controlling FSM.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width (VW < DW).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  DW  unsigned dividend, captured when start is accepted
- divisor  input  VW  unsigned divisor, captured when start is accepted
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results become valid
- quotient  output  DW  result quotient
- remainder  output  VW  result remainder
- div_zero  output  1  divisor was zero; valid with done

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; busy, done, div_zero, quotient and remainder all 0; internal counter and shift registers 0.
- States:
  - IDLE: start=1 → capture dividend into shift register, divisor into divisor register; clear partial remainder; count=0; go to CALC.
  - CALC: one restoring step per edge. After the step with count=DW-1, go to IDLE and load outputs.
- Restoring step:
  - trial = {rem, next dividend MSB}, VW+1 bits.
  - If trial >= {1'b0, divisor}: rem = (trial - divisor)[VW-1:0] and shift in quotient bit 1.
  - Otherwise: rem = trial[VW-1:0] and shift in quotient bit 0.
- Latency:
  - start high in cycle 0 (IDLE) → busy high in cycles 1..DW.
  - done high in cycle DW+1 (cycle 9 at default), with quotient, remainder and div_zero valid.
  - busy is low in the done cycle.
- Outputs hold their values until the next completed operation; they do not change when a new start is accepted.
- start while busy: ignored, with no effect on the running operation.
- start in the done cycle: accepted, because state is already IDLE, giving back-to-back operation.
- Operand inputs are don't-care except in the cycle where start is accepted.
- rst_n low mid-operation: immediate return to the reset state. No done is generated, and outputs clear to 0.
- Divisor 0 without the optional feature: the algorithm runs normally, yielding quotient = all ones and remainder = dividend[VW-1:0]. div_zero stays 0.

Optional Feature:
- Macro: SEQ_DIV_ZERO_CHK_EN.
- Defined:
  - divisor==0 at start skips CALC; done is asserted in cycle 1.
  - quotient = all ones, remainder = 0, div_zero = 1.
  - busy stays low for that operation.
- Undefined:
  - div_zero is tied to 0; divisor 0 follows the normal DW-cycle path.

Decomposition:
- Package seq_div_pkg:
  - constants DW_DEF=8 and VW_DEF=4;
  - state enum {IDLE, CALC};
  - counter width constant $clog2(DW).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, incoming bit, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- 200 ÷ 7, start pulsed in cycle 0 → done exactly in cycle 9; quotient=28, remainder=4; busy high in cycles 1–8 only.
- 255 ÷ 15 → quotient=17, remainder=0; then 255 ÷ 1 → quotient=255, remainder=0.
- 5 ÷ 9 → quotient=0, remainder=5; then a back-to-back start in the done cycle with 100 ÷ 3 → quotient=33, remainder=1.
- Divisor 0, dividend 0xA6:
  - with SEQ_DIV_ZERO_CHK_EN → done in cycle 1, quotient=0xFF, remainder=0, div_zero=1;
  - without it → done in cycle 9, quotient=0xFF, remainder=0x6, div_zero=0.
- Start 200 ÷ 7, then pulse start again with 50 ÷ 5 in cycle 4 → second start ignored; results 28/4 in cycle 9, and no second done.
- Start 200 ÷ 7, then assert rst_n low in cycle 5 → busy=0 and outputs=0 immediately; no done ever pulses for that operation.
